// File: rtl/bp_pkg.sv
// Shared types and helpers for the local 2-bit predictor table update controller.
package bp_pkg;
   localparam int IDX_W = 10;

   typedef logic [1:0] ctr_t;

   localparam ctr_t INIT_VAL = 2'b01;

   typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

   function automatic ctr_t sat_next(input ctr_t cur, input logic taken);
      ctr_t res;
      if (taken) res = (cur == 2'b11) ? cur : cur + 2'b01;
      else       res = (cur == 2'b00) ? cur : cur - 2'b01;
      return res;
   endfunction
endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO for commit updates; head visible combinationally, clear dominates push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module bp_upd_fifo #(
   parameter int DW    = 11,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clr,
   input  logic                     push,
   input  logic [DW-1:0]            pushData,
   input  logic                     pop,
   output logic [DW-1:0]            headData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic          doPush;
   logic          doPop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign doPop    = pop && !empty;
   assign doPush   = push && (!full || doPop);
   assign headData = mem[rdPtr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (clr) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush && !clr) mem[wrPtr] <= pushData;
   end
endmodule

// File: rtl/bp_update_ctrl.sv
// Predictor-table sequencer: full-table init, buffered read-modify-write updates, fetch/update read-port arbitration.
// Fetch lookups are combinational; an update takes one read cycle plus one write cycle; cm_ready drops when full, in INIT or on flush.
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             fetch_req,
   input  logic [IDX_W-1:0] fetch_pc,
   output logic [1:0]       fetch_pred,
   output logic             fetch_pred_valid,
   input  logic             cm_valid,
   output logic             cm_ready,
   input  logic [IDX_W-1:0] cm_pc,
   input  logic             cm_taken,
   input  logic             flush_req,
   output logic             flush_busy,
   output logic [IDX_W-1:0] tbl_rd_pc,
   input  logic [1:0]       tbl_rd_data,
   output logic             tbl_wr_en,
   output logic [IDX_W-1:0] tbl_wr_pc,
   output logic [1:0]       tbl_wr_data
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            nextState;
   logic [IDX_W-1:0]  idx;
   ctr_t              cur;
   logic [CNT_W-1:0]  starveCnt;
   logic [IDX_W-1:0]  headPc;
   logic              headTaken;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [FC_W-1:0]   fifoCnt;
   logic              fifoPop;
   logic              fifoClr;
   logic              cmPush;
   logic              fetchGrant;
   logic              updGrant;
   logic              bypass;

   // Fetch owns the read port until the updater has been starved STARVE_LIMIT cycles.
   assign fetchGrant = fetch_req && (starveCnt < CNT_W'(STARVE_LIMIT));
   assign updGrant   = (state == UPD_RD) && !fetchGrant;
   assign cmPush     = cm_valid && cm_ready;
   assign fifoClr    = flush_req && (state != INIT);

   bp_upd_fifo #(
      .DW    (IDX_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (fifoClr),
      .push     (cmPush),
      .pushData ({cm_pc, cm_taken}),
      .pop      (fifoPop),
      .headData ({headPc, headTaken}),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCnt)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= INIT;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         INIT:    if (idx == '1) nextState = IDLE;
         IDLE:    if (flush_req) nextState = INIT;
                  else if (!fifoEmpty) nextState = UPD_RD;
         UPD_RD:  if (flush_req) nextState = INIT;
                  else if (updGrant) nextState = UPD_WR;
         UPD_WR:  if (flush_req) nextState = INIT;
                  else if ((fifoCnt > FC_W'(1)) || cmPush) nextState = UPD_RD;
                  else nextState = IDLE;
         default: nextState = INIT;
      endcase
   end

   always_comb begin
      tbl_wr_en        = 1'b0;
      tbl_wr_pc        = headPc;
      tbl_wr_data      = sat_next(cur, headTaken);
      fifoPop          = 1'b0;
      flush_busy       = (state == INIT);
      cm_ready         = (state != INIT) && !fifoFull && !flush_req;
      tbl_rd_pc        = fetchGrant ? fetch_pc : headPc;
      fetch_pred_valid = fetchGrant && (state != INIT);
      if (state == INIT) begin
         tbl_wr_en   = 1'b1;
         tbl_wr_pc   = idx;
         tbl_wr_data = INIT_VAL;
      end else if (state == UPD_WR) begin
         tbl_wr_en = 1'b1;
         fifoPop   = 1'b1;
      end
      // The table write lands at the clock edge, so a same-cycle lookup must see the new value here.
      bypass     = (state == UPD_WR) && fetchGrant && (fetch_pc == headPc);
      fetch_pred = bypass ? tbl_wr_data : tbl_rd_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx       <= '0;
         cur       <= INIT_VAL;
         starveCnt <= '0;
      end else begin
         idx <= (state == INIT) ? idx + 1'b1 : '0;
         if (updGrant) cur <= tbl_rd_data;
         if ((state != UPD_RD) || updGrant) starveCnt <= '0;
         else if (starveCnt < CNT_W'(STARVE_LIMIT)) starveCnt <= starveCnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: a behavioural table model plus a write scoreboard checked by a monitor.
module tb_bp_update_ctrl;
   import bp_pkg::*;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             fetch_req = 1'b0;
   logic [IDX_W-1:0] fetch_pc = '0;
   logic [1:0]       fetch_pred;
   logic             fetch_pred_valid;
   logic             cm_valid = 1'b0;
   logic             cm_ready;
   logic [IDX_W-1:0] cm_pc = '0;
   logic             cm_taken = 1'b0;
   logic             flush_req = 1'b0;
   logic             flush_busy;
   logic [IDX_W-1:0] tbl_rd_pc;
   logic [1:0]       tbl_rd_data;
   logic             tbl_wr_en;
   logic [IDX_W-1:0] tbl_wr_pc;
   logic [1:0]       tbl_wr_data;

   int total = 0;
   int bad   = 0;
   logic [11:0] expQ [$];
   logic [1:0]  tbl [1024];

   always #5 clk = ~clk;

   bp_update_ctrl dut (
      .clk              (clk),
      .rstn             (rstn),
      .fetch_req        (fetch_req),
      .fetch_pc         (fetch_pc),
      .fetch_pred       (fetch_pred),
      .fetch_pred_valid (fetch_pred_valid),
      .cm_valid         (cm_valid),
      .cm_ready         (cm_ready),
      .cm_pc            (cm_pc),
      .cm_taken         (cm_taken),
      .flush_req        (flush_req),
      .flush_busy       (flush_busy),
      .tbl_rd_pc        (tbl_rd_pc),
      .tbl_rd_data      (tbl_rd_data),
      .tbl_wr_en        (tbl_wr_en),
      .tbl_wr_pc        (tbl_wr_pc),
      .tbl_wr_data      (tbl_wr_data)
   );

   assign tbl_rd_data = tbl[tbl_rd_pc];
   always @(posedge clk) if (tbl_wr_en) tbl[tbl_wr_pc] <= tbl_wr_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Every table write is popped against the expected {pc, data} queue.
   always @(negedge clk) begin
      if (rstn && tbl_wr_en) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wr: got pc=%0d data=%b, want no write", tbl_wr_pc, tbl_wr_data);
         end else begin
            check("tbl_wr", 32'({tbl_wr_pc, tbl_wr_data}), 32'(expQ.pop_front()));
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushInit();
      for (int i = 0; i < 1024; i++) expQ.push_back({10'(i), 2'b01});
   endtask

   task automatic send(input int pc, input logic tk);
      int n = 0;
      cm_valid = 1'b1;
      cm_pc    = 10'(pc);
      cm_taken = tk;
      while (!cm_ready && n < 200) begin
         cycle();
         n++;
      end
      check("cm_ready_wait", 32'(cm_ready), 32'd1);
      cycle();
      cm_valid = 1'b0;
   endtask

   task automatic fetchCheck(input string name, input int pc, input logic [1:0] want);
      fetch_req = 1'b1;
      fetch_pc  = 10'(pc);
      #1;
      check(name, 32'(fetch_pred), 32'(want));
      check({name, "_vld"}, 32'(fetch_pred_valid), 32'd1);
      cycle();
      fetch_req = 1'b0;
   endtask

   initial begin
      int n;
      // Reset: INIT outputs, even with a fetch request present.
      pushInit();
      fetch_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_flush_busy", 32'(flush_busy), 32'd1);
      check("rst_cm_ready", 32'(cm_ready), 32'd0);
      check("rst_wr_en", 32'(tbl_wr_en), 32'd1);
      check("rst_wr_pc", 32'(tbl_wr_pc), 32'd0);
      check("rst_pred_vld", 32'(fetch_pred_valid), 32'd0);
      fetch_req = 1'b0;
      rstn = 1'b1;
      repeat (1023) cycle();
      check("init_last_busy", 32'(flush_busy), 32'd1);
      check("init_last_ready", 32'(cm_ready), 32'd0);
      cycle();
      check("init_done_busy", 32'(flush_busy), 32'd0);
      check("init_done_ready", 32'(cm_ready), 32'd1);

      // Three taken updates to entry 5: 01 -> 10 -> 11 -> 11.
      expQ.push_back({10'd5, 2'b10});
      expQ.push_back({10'd5, 2'b11});
      expQ.push_back({10'd5, 2'b11});
      send(5, 1'b1);
      send(5, 1'b1);
      send(5, 1'b1);
      repeat (15) cycle();
      fetchCheck("fetch5", 5, 2'b11);

      // Starvation: fetch held high; 1 IDLE + 8 denied UPD_RD cycles, then one steal.
      fetch_req = 1'b1;
      fetch_pc  = 10'd100;
      expQ.push_back({10'd7, 2'b00});
      send(7, 1'b0);
      n = 0;
      while (fetch_pred_valid && n < 40) begin
         n++;
         cycle();
      end
      check("starve_len", 32'(n), 32'd9);
      check("steal_rd_pc", 32'(tbl_rd_pc), 32'd7);
      check("steal_vld", 32'(fetch_pred_valid), 32'd0);
      cycle();
      check("after_steal_vld", 32'(fetch_pred_valid), 32'd1);
      fetch_req = 1'b0;
      repeat (3) cycle();

      // Bypass: lookup of entry 9 in the cycle it is being written with 10.
      expQ.push_back({10'd9, 2'b10});
      send(9, 1'b1);
      n = 0;
      while (!tbl_wr_en && n < 20) begin
         n++;
         cycle();
      end
      check("byp_wait", 32'(tbl_wr_en), 32'd1);
      fetch_req = 1'b1;
      fetch_pc  = 10'd9;
      #1;
      check("byp_pred", 32'(fetch_pred), 32'd2);
      check("byp_vld", 32'(fetch_pred_valid), 32'd1);
      cycle();
      fetch_req = 1'b0;
      repeat (3) cycle();

      // Fill the FIFO while fetch hogs the port; the 5th update waits for the first pop.
      fetch_req = 1'b1;
      fetch_pc  = 10'd200;
      for (int i = 20; i < 24; i++) begin
         expQ.push_back({10'(i), 2'b10});
         send(i, 1'b1);
      end
      cm_valid = 1'b1;
      cm_pc    = 10'd24;
      cm_taken = 1'b1;
      check("full_ready", 32'(cm_ready), 32'd0);
      n = 0;
      while (!tbl_wr_en && n < 40) begin
         n++;
         cycle();
      end
      check("first_pop_wait", 32'(tbl_wr_en), 32'd1);
      check("pop_cycle_ready", 32'(cm_ready), 32'd0);
      cycle();
      check("after_pop_ready", 32'(cm_ready), 32'd1);
      expQ.push_back({10'd24, 2'b10});
      cycle();
      cm_valid  = 1'b0;
      fetch_req = 1'b0;
      repeat (20) cycle();
      check("fill_drained", 32'(expQ.size()), 32'd0);
      fetchCheck("fetch24", 24, 2'b10);
      fetchCheck("fetch20", 20, 2'b10);

      // Flush in UPD_WR with three pending: only the head write lands, then a full re-init.
      expQ.push_back({10'd30, 2'b00});
      send(30, 1'b0);
      send(31, 1'b0);
      send(32, 1'b0);
      n = 0;
      while (!tbl_wr_en && n < 20) begin
         n++;
         cycle();
      end
      check("flush_wr_pc", 32'(tbl_wr_pc), 32'd30);
      flush_req = 1'b1;
      #1;
      check("flush_ready", 32'(cm_ready), 32'd0);
      pushInit();
      cycle();
      flush_req = 1'b0;
      check("flush_busy", 32'(flush_busy), 32'd1);
      n = 0;
      // A flush pulse part-way through INIT must not restart the sweep.
      while (flush_busy && n < 1100) begin
         flush_req = (n == 100);
         cycle();
         n++;
      end
      flush_req = 1'b0;
      check("reinit_len", 32'(n), 32'd1024);
      check("reinit_ready", 32'(cm_ready), 32'd1);
      fetchCheck("fetch30", 30, 2'b01);
      fetchCheck("fetch31", 31, 2'b01);
      fetchCheck("fetch5_reinit", 5, 2'b01);
      repeat (5) cycle();
      check("all_writes_seen", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
